// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package load_store_unit_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // funct3 encodings for RV32I loads and stores.
    localparam int          F3_WIDTH = 3;
    localparam logic [2:0]  F3_BYTE  = 3'b000;
    localparam logic [2:0]  F3_HALF  = 3'b001;
    localparam logic [2:0]  F3_WORD  = 3'b010;
    localparam logic [2:0]  F3_BYTEU = 3'b100;
    localparam logic [2:0]  F3_HALFU = 3'b101;

    // Legal range of the memory read hold time, and the width of its counter.
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;
    localparam int CNT_W       = 3;

    // Width of the word index presented to the data memory.
    localparam int MADDR_W     = 9;

    // Access fault: misaligned half/word, reserved funct3, or a store with an
    // unsigned (load-only) width encoding.
    function automatic logic lsu_is_fault(input logic            is_store,
                                          input logic [F3_WIDTH-1:0] f3,
                                          input logic [1:0]      addr_lo);
        logic f;
        f = 1'b0;
        case (f3)
            F3_BYTE, F3_BYTEU: f = 1'b0;
            F3_HALF, F3_HALFU: f = addr_lo[0];
            F3_WORD:           f = |addr_lo;
            default:           f = 1'b1;
        endcase
        if (is_store && f3[2]) begin
            f = 1'b1;
        end
        return f;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request, response and data-memory signal bundle of the load/store unit.
// Latency: n/a (wiring only).
// Backpressure: req_ready low while the unit is busy; memory side has none.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    // Core request
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_load;
    logic                 req_store;
    logic [F3_WIDTH-1:0]  funct3;
    logic [31:0]          addr;
    logic [31:0]          store_data;

    // Core response
    logic                 resp_valid;
    logic [31:0]          load_data;
    logic                 access_fault;
    logic                 stall;

    // Data memory
    logic                 MemRead;
    logic                 MemWrite;
    logic [MADDR_W-1:0]   mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;

    // Load/store unit side.
    modport slave (
        input  req_valid, req_load, req_store, funct3, addr, store_data, mem_rdata,
        output req_ready, resp_valid, load_data, access_fault, stall,
               MemRead, MemWrite, mem_addr, mem_wdata
    );

    // Core plus memory side.
    modport master (
        output req_valid, req_load, req_store, funct3, addr, store_data, mem_rdata,
        input  req_ready, resp_valid, load_data, access_fault, stall,
               MemRead, MemWrite, mem_addr, mem_wdata
    );

endinterface

// File: rtl/load_store_unit_lane_mux.sv
// Byte/half lane extract-and-extend for loads, lane merge for sub-word stores.
// Latency: combinational.
// Backpressure: none.
module lsu_lane_mux
    import load_store_unit_pkg::*;
(
    input  logic [F3_WIDTH-1:0] i_funct3,
    input  logic [1:0]          i_lane,
    input  logic [31:0]         i_rword,
    input  logic [31:0]         i_store_data,
    output logic [31:0]         o_load_data,
    output logic [31:0]         o_merge_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and half-word from the fetched word.
    always_comb begin
        w_byte = i_rword[7:0];
        case (i_lane)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];
    end

    // Extend the selected lane; funct3[2] marks the unsigned variants.
    always_comb begin
        o_load_data = i_rword;
        case (i_funct3[1:0])
            2'b00:   o_load_data = {{24{w_byte[7]  & ~i_funct3[2]}}, w_byte};
            2'b01:   o_load_data = {{16{w_half[15] & ~i_funct3[2]}}, w_half};
            default: o_load_data = i_rword;
        endcase
    end

    // Replace the addressed lane of the fetched word with the store data.
    always_comb begin
        o_merge_word = i_rword;
        case (i_funct3[1:0])
            2'b00: begin
                case (i_lane)
                    2'd0:    o_merge_word[7:0]   = i_store_data[7:0];
                    2'd1:    o_merge_word[15:8]  = i_store_data[7:0];
                    2'd2:    o_merge_word[23:16] = i_store_data[7:0];
                    default: o_merge_word[31:24] = i_store_data[7:0];
                endcase
            end
            2'b01: begin
                if (i_lane[1]) begin
                    o_merge_word[31:16] = i_store_data[15:0];
                end else begin
                    o_merge_word[15:0]  = i_store_data[15:0];
                end
            end
            default: o_merge_word = i_store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, read-modify-write for SB/SH.
// Latency: load 1+MEM_LATENCY, SW 2, SB/SH 2+MEM_LATENCY, fault 1 (accept edge to resp sample).
// Backpressure: req_ready only in IDLE; requests outside IDLE are ignored.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   io_bus
);

    // Out-of-range latencies are clamped so the counter compare stays meaningful.
    localparam int LP_LAT = (MEM_LATENCY < MEM_LAT_MIN) ? MEM_LAT_MIN :
                            (MEM_LATENCY > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LATENCY;
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LP_LAT - 1);

    lsu_state_e            r_state;
    lsu_state_e            w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [31:0]           r_addr;
    logic [F3_WIDTH-1:0]   r_funct3;
    logic [31:0]           r_store_data;
    logic                  r_is_store;
    logic                  r_fault;
    logic [31:0]           r_rword;

    logic                  w_accept;
    logic                  w_kind_store;
    logic                  w_fault_in;
    logic                  w_read_last;
    logic [31:0]           w_load_data;
    logic [31:0]           w_merge_word;
    logic                  w_unused_addr;

    // Both kinds set is treated as a load.
    assign w_kind_store = io_bus.req_store & ~io_bus.req_load;
    assign w_fault_in   = lsu_is_fault(w_kind_store, io_bus.funct3, io_bus.addr[1:0]);
    assign w_read_last  = (r_cnt == LP_LAST);

    // Only addr[10:0] addresses the 512-word data memory.
    assign w_unused_addr = &{1'b0, r_addr[31:11]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; faults skip memory entirely, SW skips the read.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.req_valid && (io_bus.req_load || io_bus.req_store)) begin
                    w_accept = 1'b1;
                    if (w_fault_in) begin
                        w_state_nxt = ST_RESP;
                    end else if (w_kind_store && (io_bus.funct3 == F3_WORD)) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (w_read_last) begin
                    w_state_nxt = r_is_store ? ST_WRITE : ST_RESP;
                end
            end
            ST_WRITE: w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, read-hold counter and read-word capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_addr       <= '0;
            r_funct3     <= '0;
            r_store_data <= '0;
            r_is_store   <= 1'b0;
            r_fault      <= 1'b0;
            r_rword      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr       <= io_bus.addr;
                        r_funct3     <= io_bus.funct3;
                        r_store_data <= io_bus.store_data;
                        r_is_store   <= w_kind_store;
                        r_fault      <= w_fault_in;
                        r_cnt        <= '0;
                    end
                end
                ST_READ: begin
                    if (w_read_last) begin
                        r_rword <= io_bus.mem_rdata;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    lsu_lane_mux u_lane_mux (
        .i_funct3     (r_funct3),
        .i_lane       (r_addr[1:0]),
        .i_rword      (r_rword),
        .i_store_data (r_store_data),
        .o_load_data  (w_load_data),
        .o_merge_word (w_merge_word)
    );

    // Outputs decode straight from state so reset drives them to idle values.
    assign io_bus.req_ready    = (r_state == ST_IDLE);
    assign io_bus.stall        = (r_state != ST_IDLE);
    assign io_bus.MemRead      = (r_state == ST_READ);
    assign io_bus.MemWrite     = (r_state == ST_WRITE);
    assign io_bus.mem_addr     = r_addr[10:2];
    assign io_bus.mem_wdata    = (r_state == ST_WRITE) ? w_merge_word : '0;
    assign io_bus.resp_valid   = (r_state == ST_RESP);
    assign io_bus.access_fault = (r_state == ST_RESP) & r_fault;
    assign io_bus.load_data    = ((r_state == ST_RESP) && !r_fault && !r_is_store)
                                 ? w_load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: two units (MEM_LATENCY 1 and 3) driven by one request stream.
// Latency: checked per response against hand-derived cycle counts.
// Backpressure: requests issued only when both units show req_ready.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit_if bus1();
    load_store_unit_if bus3();

    load_store_unit #(.MEM_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .io_bus(bus1));
    load_store_unit #(.MEM_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .io_bus(bus3));

    // Shared request stimulus
    logic        s_valid = 1'b0;
    logic        s_load  = 1'b0;
    logic        s_store = 1'b0;
    logic [2:0]  s_f3    = 3'b000;
    logic [31:0] s_addr  = 32'h0;
    logic [31:0] s_sdata = 32'h0;

    assign bus1.req_valid = s_valid;  assign bus3.req_valid = s_valid;
    assign bus1.req_load  = s_load;   assign bus3.req_load  = s_load;
    assign bus1.req_store = s_store;  assign bus3.req_store = s_store;
    assign bus1.funct3    = s_f3;     assign bus3.funct3    = s_f3;
    assign bus1.addr      = s_addr;   assign bus3.addr      = s_addr;
    assign bus1.store_data= s_sdata;  assign bus3.store_data= s_sdata;

    // Data memories, word i preloaded with i
    logic [31:0] mem1 [512];
    logic [31:0] mem3 [512];
    bit          mem_ready = 1'b0;

    assign bus1.mem_rdata = mem1[bus1.mem_addr];
    assign bus3.mem_rdata = mem3[bus3.mem_addr];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) begin
                mem1[i] <= 32'(i);
                mem3[i] <= 32'(i);
            end
            mem_ready <= 1'b1;
        end else begin
            if (bus1.MemWrite) mem1[bus1.mem_addr] <= bus1.mem_wdata;
            if (bus3.MemWrite) mem3[bus3.mem_addr] <= bus3.mem_wdata;
        end
    end

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        fault;
        int          acc;
        int          lat;
        int          nrd;
        int          nwr;
        logic [8:0]  maddr;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    int   rdc[2];
    int   wrc[2];

    task automatic cmp(input string name, input string who, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s %s: got 0x%08h required 0x%08h", name, who, act, req);
        end
    endtask

    // Per-unit monitor: counts strobes and checks each response against the queue head.
    task automatic mon(input int d, input logic mr, input logic mw, input logic rv,
                       input logic af, input logic stl, input logic [31:0] ld,
                       input logic [8:0] ma);
        exp_t  e;
        string who;
        who = (d == 0) ? "lat1" : "lat3";
        rdc[d] += int'(mr);
        wrc[d] += int'(mw);
        if (mr || mw) cmp("strobe_excl", who, 32'(mr & mw), 32'd0);
        if (rv) begin
            if ((d == 0 && q1.size() == 0) || (d == 1 && q3.size() == 0)) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp %s: got resp_valid 1 required no response", who);
            end else begin
                if (d == 0) e = q1.pop_front();
                else        e = q3.pop_front();
                cmp({e.name, "_data"},  who, ld, e.data);
                cmp({e.name, "_fault"}, who, 32'(af), 32'(e.fault));
                cmp({e.name, "_lat"},   who, 32'(cyc + 1 - e.acc), 32'(e.lat));
                cmp({e.name, "_nrd"},   who, 32'(rdc[d]), 32'(e.nrd));
                cmp({e.name, "_nwr"},   who, 32'(wrc[d]), 32'(e.nwr));
                cmp({e.name, "_stall"}, who, 32'(stl), 32'd1);
                if (!e.fault) cmp({e.name, "_maddr"}, who, 32'(ma), 32'(e.maddr));
            end
            rdc[d] = 0;
            wrc[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus1.MemRead, bus1.MemWrite, bus1.resp_valid, bus1.access_fault,
            bus1.stall, bus1.load_data, bus1.mem_addr);
        mon(1, bus3.MemRead, bus3.MemWrite, bus3.resp_valid, bus3.access_fault,
            bus3.stall, bus3.load_data, bus3.mem_addr);
    end

    task automatic wait_ready(output bit ok);
        int n;
        n  = 0;
        @(negedge clk);
        while (!(bus1.req_ready && bus3.req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 100);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got req_ready low for 100 cycles required high");
        end
    endtask

    // Push expectations for both units, then present the request for one edge.
    task automatic issue(input string name, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] xdata, input logic xfault);
        bit   ok;
        exp_t e;
        logic is_st;
        logic sub;
        wait_ready(ok);
        if (!ok) return;
        is_st = st & ~ld;
        sub   = is_st && (f3 != F3_WORD);
        for (int k = 0; k < 2; k++) begin
            int lat_m;
            lat_m   = (k == 0) ? 1 : 3;
            e.name  = name;
            e.data  = xdata;
            e.fault = xfault;
            e.acc   = cyc + 1;
            e.maddr = a[10:2];
            e.lat   = xfault ? 1 : (is_st ? (sub ? 2 + lat_m : 2) : 1 + lat_m);
            e.nrd   = (xfault || (is_st && !sub)) ? 0 : lat_m;
            e.nwr   = (!xfault && is_st) ? 1 : 0;
            if (k == 0) q1.push_back(e);
            else        q3.push_back(e);
        end
        s_valid = 1'b1; s_load = ld; s_store = st; s_f3 = f3; s_addr = a; s_sdata = sd;
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_load = 1'b0; s_store = 1'b0;
    endtask

    initial begin
        bit ok;
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_ctl", "lat1", 32'({bus1.req_ready, bus1.resp_valid, bus1.stall,
            bus1.MemRead, bus1.MemWrite, bus1.access_fault}), 32'b100000);
        cmp("rst_ctl", "lat3", 32'({bus3.req_ready, bus3.resp_valid, bus3.stall,
            bus3.MemRead, bus3.MemWrite, bus3.access_fault}), 32'b100000);
        cmp("rst_ld",  "lat1", bus1.load_data | bus1.mem_wdata | 32'(bus1.mem_addr), 32'h0);
        cmp("rst_ld",  "lat3", bus3.load_data | bus3.mem_wdata | 32'(bus3.mem_addr), 32'h0);
        rst_n = 1'b1;

        // Basic load, accepted on the first edge after reset release
        issue("lb_0c",  1, 0, F3_BYTE,  32'h0C, 32'h0,        32'h00000003, 0);
        // Word store then sign/zero extension across lanes
        issue("sw_10",  0, 1, F3_WORD,  32'h10, 32'h80FF7F01, 32'h0,        0);
        issue("lb_11",  1, 0, F3_BYTE,  32'h11, 32'h0,        32'h0000007F, 0);
        issue("lb_12",  1, 0, F3_BYTE,  32'h12, 32'h0,        32'hFFFFFFFF, 0);
        issue("lhu_12", 1, 0, F3_HALFU, 32'h12, 32'h0,        32'h000080FF, 0);
        issue("lh_12",  1, 0, F3_HALF,  32'h12, 32'h0,        32'hFFFF80FF, 0);
        issue("lb_10",  1, 0, F3_BYTE,  32'h10, 32'h0,        32'h00000001, 0);
        issue("lhu_10", 1, 0, F3_HALFU, 32'h10, 32'h0,        32'h00007F01, 0);
        // Byte store into the top lane (read-modify-write)
        issue("sb_13",  0, 1, F3_BYTE,  32'h13, 32'h000000AA, 32'h0,        0);
        issue("lw_10",  1, 0, F3_WORD,  32'h10, 32'h0,        32'hAAFF7F01, 0);
        // Faults: misaligned, reserved funct3, unsigned width on a store
        issue("lw_06",  1, 0, F3_WORD,  32'h06, 32'h0,        32'h0,        1);
        issue("sh_05",  0, 1, F3_HALF,  32'h05, 32'h1234,     32'h0,        1);
        issue("ld_011", 1, 0, 3'b011,   32'h00, 32'h0,        32'h0,        1);
        issue("ld_111", 1, 0, 3'b111,   32'h00, 32'h0,        32'h0,        1);
        issue("sb_100", 0, 1, 3'b100,   32'h00, 32'h55,       32'h0,        1);
        // Both kinds set behaves as a load (no write)
        issue("ldst_04", 1, 1, F3_WORD, 32'h04, 32'hDEADBEEF, 32'h00000001, 0);
        // Half store into upper lane
        issue("sh_22",  0, 1, F3_HALF,  32'h22, 32'h00001234, 32'h0,        0);
        issue("lw_20",  1, 0, F3_WORD,  32'h20, 32'h0,        32'h12340008, 0);
        issue("lbu_23", 1, 0, F3_BYTEU, 32'h23, 32'h0,        32'h00000012, 0);
        issue("lh_22",  1, 0, F3_HALF,  32'h22, 32'h0,        32'h00001234, 0);

        // Request with neither kind is ignored
        wait_ready(ok);
        if (ok) begin
            s_valid = 1'b1; s_f3 = F3_WORD; s_addr = 32'h40;
            @(posedge clk);
            #1;
            cmp("nokind_rdy", "lat1", 32'(bus1.req_ready), 32'd1);
            cmp("nokind_rdy", "lat3", 32'(bus3.req_ready), 32'd1);
            s_valid = 1'b0;
        end

        // Reset while an SB is in READ: abort, no write, word untouched
        wait_ready(ok);
        if (ok) begin
            s_valid = 1'b1; s_load = 1'b0; s_store = 1'b1; s_f3 = F3_BYTE;
            s_addr = 32'h30; s_sdata = 32'hEE;
            @(posedge clk);
            #1;
            s_valid = 1'b0; s_store = 1'b0;
            cmp("abort_inread", "lat1", 32'(bus1.MemRead), 32'd1);
            rst_n = 1'b0;
            #1;
            cmp("abort_idle", "lat1", 32'({bus1.req_ready, bus1.MemRead, bus1.MemWrite}), 32'b100);
            cmp("abort_idle", "lat3", 32'({bus3.req_ready, bus3.MemRead, bus3.MemWrite}), 32'b100);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
        issue("lw_30",  1, 0, F3_WORD,  32'h30, 32'h0,        32'h0000000C, 0);

        // Drain outstanding responses
        n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        cmp("drain", "lat1", 32'(q1.size()), 32'd0);
        cmp("drain", "lat3", 32'(q3.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
